// File: rtl/clockworks.sv
// clockworks -- clock and reset conditioning for the SoC core.
//
// Derives a slowed system clock from the board clock by a power-of-two
// divider, so the core can be single-stepped visibly on LEDs. Also generates
// a stretched system reset that is held at power-up and after every reset
// request. The stretched reset is released only on a sys_clk falling edge,
// so it is always stable around the core's rising edges.
//
// Parameters:
//   SLOW        divider exponent 0..24; sys_clk = clk / 2^SLOW (0 = clk itself)
//   RESET_HOLD  sys_clk periods (>= 1) that sys_reset stays high after reset
//
// Ports:
//   clk        in   board clock; every register uses its rising edge
//   reset      in   reset request, synchronous, active-high
//   sys_clk    out  divided clock for the core
//   sys_ce     out  one-clk-cycle pulse just before each sys_clk rising edge
//   sys_reset  out  stretched active-high system reset
module clockworks #(
  parameter int SLOW       = 0,
  parameter int RESET_HOLD = 16
) (
  input  logic clk,
  input  logic reset,
  output logic sys_clk,
  output logic sys_ce,
  output logic sys_reset
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RESET_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  // True on the clk edge that will drop sys_clk. The stretcher advances only
  // here, which keeps sys_reset transitions on sys_clk falling edges.
  logic fall_event;

  // Power-up values come from the FPGA configuration, so the core is held in
  // reset even if the reset button is never pressed.
  logic [HW-1:0] hold_reg      = '0;
  logic          sys_reset_reg = 1'b1;

  generate
    if (SLOW == 0) begin : g_nodiv
      // No division: the core runs directly on the board clock and every
      // cycle counts as a sys_clk period.
      assign sys_clk    = clk;
      assign sys_ce     = 1'b1;
      assign fall_event = 1'b1;
    end else begin : g_div
      // All ones: last count of the period, sys_clk falls on the next edge.
      localparam logic [SLOW-1:0] DIV_LAST = '1;
      // 2^(SLOW-1)-1: last count of the low half, sys_clk rises next edge.
      localparam logic [SLOW-1:0] DIV_CE   = DIV_LAST >> 1;

      logic [SLOW-1:0] div_reg = '0;

      always_ff @(posedge clk) begin
        if (reset) begin
          div_reg <= '0;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end

      // MSB of the counter is a register bit, so sys_clk is glitch-free.
      assign sys_clk    = div_reg[SLOW-1];
      assign sys_ce     = (div_reg == DIV_CE);
      assign fall_event = (div_reg == DIV_LAST);
    end
  endgenerate

  // Reset stretcher: count sys_clk periods since the last reset request and
  // release sys_reset on the edge that completes the RESET_HOLD-th period.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg      <= '0;
      sys_reset_reg <= 1'b1;
    end else if (fall_event) begin
      if (hold_reg < HOLD_MAX) begin
        hold_reg <= hold_reg + 1'b1;
      end
      if (hold_reg == HOLD_LAST) begin
        sys_reset_reg <= 1'b0;
      end
    end
  end

  assign sys_reset = sys_reset_reg;

endmodule

// File: tb/tb_clockworks.sv
// Testbench for clockworks. Four instances run side by side on one clock:
//   0: SLOW=2 RESET_HOLD=3   long reset, re-assert during stretch, later
//                            single pulse and a long held reset
//   1: SLOW=0 RESET_HOLD=16  no division, single-cycle reset pulses
//   2: SLOW=1 RESET_HOLD=4   reset never asserted (power-up release only)
//   3: SLOW=3 RESET_HOLD=5   one-cycle reset while sys_clk is high
// A timing model (edges since the last edge that sampled reset) predicts the
// outputs; predictions are queued when stimulus is driven and compared after
// the following clock edge.
module tb_clockworks;

  localparam int N_CYC = 1200;
  localparam int SL[4] = '{2, 0, 1, 3};
  localparam int HL[4] = '{3, 16, 4, 5};

  logic       clk = 1'b0;
  logic [3:0] rst_v = 4'b0001;
  logic [3:0] sclk, sce, srst;

  always #5 clk = ~clk;

  clockworks #(.SLOW(2), .RESET_HOLD(3)) u_a (
    .clk(clk), .reset(rst_v[0]), .sys_clk(sclk[0]), .sys_ce(sce[0]), .sys_reset(srst[0]));
  clockworks #(.SLOW(0), .RESET_HOLD(16)) u_b (
    .clk(clk), .reset(rst_v[1]), .sys_clk(sclk[1]), .sys_ce(sce[1]), .sys_reset(srst[1]));
  clockworks #(.SLOW(1), .RESET_HOLD(4)) u_c (
    .clk(clk), .reset(rst_v[2]), .sys_clk(sclk[2]), .sys_ce(sce[2]), .sys_reset(srst[2]));
  clockworks #(.SLOW(3), .RESET_HOLD(5)) u_d (
    .clk(clk), .reset(rst_v[3]), .sys_clk(sclk[3]), .sys_ce(sce[3]), .sys_reset(srst[3]));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model in terms of tt = clk edges since the last edge sampling reset=1
  // (or since power-up).
  function automatic int period(input int i);
    return 1 << SL[i];
  endfunction

  function automatic logic exp_clk(input int i, input int tt, input logic clkv);
    if (SL[i] == 0) return clkv;
    return (tt % period(i)) >= (period(i) / 2);
  endfunction

  function automatic logic exp_ce(input int i, input int tt);
    if (SL[i] == 0) return 1'b1;
    return (tt % period(i)) == (period(i) / 2 - 1);
  endfunction

  function automatic logic exp_rst(input int i, input int tt);
    return tt < HL[i] * period(i);
  endfunction

  typedef struct {
    logic [3:0] clk_e;
    logic [3:0] ce_e;
    logic [3:0] rst_e;
  } exp_t;

  exp_t sb[$];

  initial begin
    exp_t       e;
    exp_t       o;
    logic [3:0] r;
    logic [3:0] prev_clk;
    logic [3:0] prev_rst;
    int         t[4];
    int         last_rst[4];
    int         last_rise[4];
    int         ce_cnt[4];
    int         fell[4];
    bit         d_done;
    int         d_hit;

    d_done = 1'b0;
    d_hit  = -1;
    for (int i = 0; i < 4; i++) begin
      t[i]         = 0;
      last_rst[i]  = 0;
      last_rise[i] = -1;
      ce_cnt[i]    = 0;
      fell[i]      = 0;
    end

    // Power-up state, before any clock edge (clk is low here).
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("pu_clk%0d", i), int'(sclk[i]), int'(exp_clk(i, 0, 1'b0)));
      check_val($sformatf("pu_ce%0d", i),  int'(sce[i]),  int'(exp_ce(i, 0)));
      check_val($sformatf("pu_rst%0d", i), int'(srst[i]), int'(exp_rst(i, 0)));
    end
    prev_clk = sclk;
    prev_rst = srst;

    for (int c = 1; c <= N_CYC; c++) begin
      // Stimulus for edge c.
      r[0] = (c <= 5) || (c == 14) || (c == 200) || (c >= 300 && c <= 340);
      r[1] = (c == 3) || (c == 500);
      r[2] = 1'b0;
      // t[3] % 8 == 5 means sys_clk of instance 3 is currently high (div=5).
      r[3] = (c >= 100) && !d_done && ((t[3] % 8) == 5);
      if (r[3]) begin
        d_done = 1'b1;
        d_hit  = c;
      end
      rst_v = r;

      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          t[i]        = 0;
          last_rst[i] = c;
        end else begin
          t[i]++;
        end
        e.clk_e[i] = exp_clk(i, t[i], 1'b1);
        e.ce_e[i]  = exp_ce(i, t[i]);
        e.rst_e[i] = exp_rst(i, t[i]);
      end
      sb.push_back(e);

      @(posedge clk);
      #1;
      o = sb.pop_front();

      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("clk%0d@%0d", i, c), int'(sclk[i]), int'(o.clk_e[i]));
        check_val($sformatf("ce%0d@%0d", i, c),  int'(sce[i]),  int'(o.ce_e[i]));
        check_val($sformatf("rst%0d@%0d", i, c), int'(srst[i]), int'(o.rst_e[i]));

        // Release position relative to the last reset request.
        if (prev_rst[i] && !srst[i]) begin
          fell[i]++;
          check_val($sformatf("fall_edge%0d@%0d", i, c), c - last_rst[i], HL[i] * period(i));
        end

        if (SL[i] >= 1) begin
          if (!prev_clk[i] && sclk[i]) begin
            check_val($sformatf("rst_stable_on_rise%0d@%0d", i, c), int'(srst[i]), int'(prev_rst[i]));
            if (last_rise[i] > last_rst[i]) begin
              check_val($sformatf("period%0d@%0d", i, c), c - last_rise[i], period(i));
              check_val($sformatf("ce_per_period%0d@%0d", i, c), ce_cnt[i], 1);
            end else begin
              check_val($sformatf("first_rise%0d@%0d", i, c), c - last_rst[i], period(i) / 2);
            end
            last_rise[i] = c;
            ce_cnt[i]    = int'(sce[i]);
          end else begin
            ce_cnt[i] += int'(sce[i]);
          end
        end
      end

      // Reset applied while sys_clk was high: it must drop immediately.
      if (c == d_hit) begin
        check_val("midop_was_high", int'(prev_clk[3]), 1);
        check_val("midop_clk_low",  int'(sclk[3]), 0);
        check_val("midop_rst_high", int'(srst[3]), 1);
      end

      prev_clk = sclk;
      prev_rst = srst;
      @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("released%0d", i), int'(fell[i] > 0), 1);
    end
    check_val("midop_applied", int'(d_hit > 0), 1);
    check_val("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clockworks.md
# clockworks

Clock and reset conditioning block at the top of the SoC, between the board oscillator/reset button and the processor and memory. It derives the system clock `sys_clk` as a power-of-two division of `clk`, so the core can be slowed down for visible LED stepping. It also generates a stretched, glitch-free system reset `sys_reset` that is asserted at power-up and on every `reset` request, and released only after a fixed number of `sys_clk` periods.

## Interface
- `SLOW`, default 0 — divider exponent, 0..24; `sys_clk` = `clk` / 2^`SLOW`; 0 = no division.
- `RESET_HOLD`, default 16 — number of `sys_clk` periods (≥1) for which `sys_reset` stays high after `reset` is released.

- `clk` input 1 — board clock; all internal registers are clocked on its rising edge.
- `reset` input 1 — reset request; synchronous, active-high.
- `sys_clk` output 1 — divided clock for the core.
- `sys_ce` output 1 — one-`clk`-cycle pulse preceding each `sys_clk` rising edge.
- `sys_reset` output 1 — active-high system reset, stretched.

Clock and reset convention: reset `reset`, synchronous, active-high; clock `clk`.

## Operation
- Divider: `SLOW`-bit free-running counter `div`, +1 per `clk` edge, wraps 2^`SLOW`−1 → 0.
  - `SLOW`≥1: `sys_clk` = `div[SLOW-1]`, a register bit; it is high while `div` ≥ 2^(`SLOW`−1).
  - `SLOW`=0: `sys_clk` = `clk`, a direct wire; no counter exists.
- `sys_ce`, combinational:
  - `SLOW`≥1: 1 when `div` == 2^(`SLOW`−1)−1.
  - `SLOW`=0: constant 1.
- Fall event: `div` == 2^`SLOW`−1, i.e. the next `clk` edge drops `sys_clk`. For `SLOW`=0 this event is true every cycle.
- Reset stretcher: saturating counter `hold`, width ⌈log2(`RESET_HOLD`+1)⌉, plus the `sys_reset` register.
  - While `reset`=1 at a `clk` edge: `div`←0, `hold`←0, `sys_reset`←1.
  - While `reset`=0, at each fall event:
    - if `hold` < `RESET_HOLD`: `hold`←`hold`+1;
    - if `hold`+1 == `RESET_HOLD`: `sys_reset`←0 at that same edge.
  - Once `hold` == `RESET_HOLD`, `hold` saturates and `sys_reset` stays 0 until the next `reset`.
- `sys_reset` changes only on `sys_clk` falling edges (when `SLOW`≥1). It is therefore stable around every `sys_clk` rising edge in the core domain.
- Power-up: register initial values `div`=0, `hold`=0, `sys_reset`=1. The core is held in reset after configuration even if `reset` never pulses.

## Timing
- Output values while `reset` is high and one edge after: `sys_clk`=0 (`SLOW`≥1), `sys_reset`=1, `sys_ce`=0 (`SLOW`≥2), `sys_ce`=1 (`SLOW`≤1).
- `sys_clk` period is 2^`SLOW` `clk` cycles, 50% duty.
- First `sys_clk` rise: 2^(`SLOW`−1) `clk` edges after the last edge sampling `reset`=1.
- `sys_reset` release: falls exactly `RESET_HOLD`·2^`SLOW` `clk` edges after the last edge sampling `reset`=1.
- Reset mid-operation:
  - `sys_reset` rises at the first edge sampling `reset`=1.
  - `div` clears at that edge, so a `sys_clk` high phase may be truncated. This is allowed because the core is in reset.
  - The release count restarts from zero.
- A `reset` pulse of one `clk` cycle is sufficient and produces the full stretch.
- `reset` re-asserted during the stretch: `hold` clears and the full `RESET_HOLD` is counted again.
- `reset` held high: `sys_reset` stays 1 indefinitely and `sys_clk` stays 0.

## Test plan
- `SLOW`=2, `RESET_HOLD`=3; `reset`=1 for 5 cycles, then 0 → `sys_clk` pattern 0,0,1,1 repeating; first rise 2 edges after release; `sys_reset` falls at edge 12 after release; `sys_ce` high when `div`==1.
- `SLOW`=0, `RESET_HOLD`=16; `reset` pulse of 1 cycle → `sys_clk` equals `clk`, `sys_ce`=1 always, `sys_reset` falls exactly 16 edges after the pulse.
- Power-up with `reset` held 0, `SLOW`=1, `RESET_HOLD`=4 → `sys_reset`=1 from time 0 and falls at edge 8.
- `SLOW`=3; assert `reset` for 1 cycle while `div`=5 (`sys_clk` high) → next edge: `sys_clk`=0, `div`=0, `sys_reset`=1; stretch restarts.
- `SLOW`=2, `RESET_HOLD`=3; re-assert `reset` at edge 9 of the stretch → `sys_reset` stays 1 and falls 12 edges after the second release.
- Any config, long run (≥1000 cycles) → `sys_clk` period constant at 2^`SLOW`; `sys_reset` never toggles on an edge where `sys_clk` rises; `sys_ce` pulses exactly once per `sys_clk` period.
